// File: rtl/gpio_mmio_slave.sv
// gpio_mmio_slave: memory-mapped GPIO block with two input ports, two output
// ports, a sticky change-status register and a level interrupt. Each bus
// access walks IDLE -> BUSY -> ACK, so one access takes at least 3 cycles.
module gpio_mmio_slave #(
  parameter logic [31:0] RST_GPO1 = 32'h0000_0000,
  parameter logic [31:0] RST_GPO2 = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req,
  input  logic        we,
  input  logic [2:0]  addr,
  input  logic [31:0] wd,
  output logic [31:0] rd,
  output logic        ack,
  input  logic [31:0] gpI1,
  input  logic [31:0] gpI2,
  output logic [31:0] gpO1,
  output logic [31:0] gpO2,
  output logic        irq
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    ACK  = 2'd2
  } state_t;

  state_t      state_r;
  logic [2:0]  addr_r;
  logic        we_r;
  logic [31:0] wd_r;

  logic [31:0] sync1_1_r, sync2_1_r, prev1_r;
  logic [31:0] sync1_2_r, sync2_2_r, prev2_r;
  logic [1:0]  warm_r;
  logic [1:0]  status_r;

  logic        wr_s;
  logic [1:0]  change_s;
  logic [1:0]  clr_s;
  logic [1:0]  status_next_s;
  logic [31:0] gpo1_next_s;
  logic [31:0] gpo2_next_s;
  logic [31:0] rd_next_s;

  // Register-map read decode; unmapped words read as zero.
  function automatic logic [31:0] read_mux(input logic [2:0]  a,
                                           input logic [31:0] g1,
                                           input logic [31:0] g2,
                                           input logic [31:0] o1,
                                           input logic [31:0] o2,
                                           input logic [1:0]  st);
    logic [31:0] v;
    case (a)
      3'd0:    v = g1;
      3'd1:    v = g2;
      3'd2:    v = o1;
      3'd3:    v = o2;
      3'd4:    v = {30'd0, st};
      default: v = 32'h0000_0000;
    endcase
    return v;
  endfunction

  // Next-state values for the writable registers and the value rd will load;
  // rd sees post-write contents so a write returns what was stored.
  always_comb begin
    wr_s          = (state_r == BUSY) && we_r;
    change_s      = 2'b00;
    clr_s         = 2'b00;
    gpo1_next_s   = gpO1;
    gpo2_next_s   = gpO2;
    if (warm_r == 2'd3) begin
      change_s[0] = (sync2_1_r != prev1_r);
      change_s[1] = (sync2_2_r != prev2_r);
    end else begin
      change_s    = 2'b00;
    end
    if (wr_s && (addr_r == 3'd2)) begin
      gpo1_next_s = wd_r;
    end else begin
      gpo1_next_s = gpO1;
    end
    if (wr_s && (addr_r == 3'd3)) begin
      gpo2_next_s = wd_r;
    end else begin
      gpo2_next_s = gpO2;
    end
    if (wr_s && (addr_r == 3'd4)) begin
      clr_s       = wd_r[1:0];
    end else begin
      clr_s       = 2'b00;
    end
    // A change event in the same cycle as a clear keeps the bit set.
    status_next_s = (status_r & ~clr_s) | change_s;
    rd_next_s     = read_mux(addr_r, sync2_1_r, sync2_2_r,
                             gpo1_next_s, gpo2_next_s, status_next_s);
  end

  // Bus handshake FSM: capture request in IDLE, execute in BUSY, pulse ack.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_r <= IDLE;
      addr_r  <= 3'd0;
      we_r    <= 1'b0;
      wd_r    <= 32'h0000_0000;
      rd      <= 32'h0000_0000;
      ack     <= 1'b0;
    end else begin
      case (state_r)
        IDLE: begin
          ack <= 1'b0;
          if (req) begin
            state_r <= BUSY;
            addr_r  <= addr;
            we_r    <= we;
            wd_r    <= wd;
          end else begin
            state_r <= IDLE;
          end
        end
        BUSY: begin
          state_r <= ACK;
          ack     <= 1'b1;
          rd      <= rd_next_s;
        end
        ACK: begin
          state_r <= IDLE;
          ack     <= 1'b0;
        end
        default: begin
          state_r <= IDLE;
          ack     <= 1'b0;
        end
      endcase
    end
  end

  // Output registers, sticky status and the interrupt that trails status.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      gpO1     <= RST_GPO1;
      gpO2     <= RST_GPO2;
      status_r <= 2'b00;
      irq      <= 1'b0;
    end else begin
      gpO1     <= gpo1_next_s;
      gpO2     <= gpo2_next_s;
      status_r <= status_next_s;
      irq      <= |status_r;
    end
  end

  // Two-flop input synchronizers, change-detect history and warm-up counter.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      sync1_1_r <= 32'h0000_0000;
      sync2_1_r <= 32'h0000_0000;
      prev1_r   <= 32'h0000_0000;
      sync1_2_r <= 32'h0000_0000;
      sync2_2_r <= 32'h0000_0000;
      prev2_r   <= 32'h0000_0000;
      warm_r    <= 2'd0;
    end else begin
      sync1_1_r <= gpI1;
      sync2_1_r <= sync1_1_r;
      prev1_r   <= sync2_1_r;
      sync1_2_r <= gpI2;
      sync2_2_r <= sync1_2_r;
      prev2_r   <= sync2_2_r;
      if (warm_r != 2'd3) begin
        warm_r <= warm_r + 2'd1;
      end else begin
        warm_r <= warm_r;
      end
    end
  end

endmodule

// File: tb/tb_gpio_mmio_slave.sv
// Testbench for gpio_mmio_slave: directed scenarios plus randomized accesses
// checked against a register-level reference model.
module tb_gpio_mmio_slave;

  localparam logic [31:0] P_GPO1 = 32'h1234_5678;
  localparam logic [31:0] P_GPO2 = 32'hA5A5_0F0F;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        req = 1'b0;
  logic        we = 1'b0;
  logic [2:0]  addr = 3'd0;
  logic [31:0] wd = 32'h0;
  logic [31:0] rd;
  logic        ack;
  logic [31:0] gpI1, gpI2, gpO1, gpO2;
  logic        irq;
  logic [31:0] gpi1_drv = 32'h0;
  logic [31:0] gpi2_drv = 32'h0;
  logic        loop_en = 1'b0;

  int checks = 0;
  int failures = 0;

  // Reference model: architectural register contents only.
  logic [31:0] m_gpo1, m_gpo2, m_gpi1, m_gpi2;
  logic [1:0]  m_status;

  assign gpI1 = gpi1_drv;
  assign gpI2 = loop_en ? gpO1 : gpi2_drv;

  gpio_mmio_slave #(.RST_GPO1(P_GPO1), .RST_GPO2(P_GPO2)) dut (
    .clk(clk), .rst(rst), .req(req), .we(we), .addr(addr), .wd(wd),
    .rd(rd), .ack(ack), .gpI1(gpI1), .gpI2(gpI2), .gpO1(gpO1), .gpO2(gpO2),
    .irq(irq)
  );

  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  function automatic logic [31:0] model_read(input logic [2:0] a);
    case (a)
      3'd0:    return m_gpi1;
      3'd1:    return m_gpi2;
      3'd2:    return m_gpo1;
      3'd3:    return m_gpo2;
      3'd4:    return {30'd0, m_status};
      default: return 32'h0;
    endcase
  endfunction

  task automatic model_write(input logic [2:0] a, input logic [31:0] d);
    case (a)
      3'd2:    m_gpo1 = d;
      3'd3:    m_gpo2 = d;
      3'd4:    m_status = m_status & ~d[1:0];
      default: ;
    endcase
  endtask

  // One bus access, started just after a rising edge; returns rd and the
  // number of edges until ack, then idles one edge so the FSM is back in IDLE.
  task automatic access(input logic w, input logic [2:0] a, input logic [31:0] d,
                        output logic [31:0] r, output int lat);
    req = 1'b1; we = w; addr = a; wd = d; lat = 0; r = 32'h0;
    for (int i = 1; i <= 8; i++) begin
      @(posedge clk); #1;
      if (ack === 1'b1) begin lat = i; r = rd; break; end
    end
    req = 1'b0; we = 1'b0;
    if (lat == 0) begin
      checks++; failures++;
      $display("FAIL access_timeout addr=%0d got no ack, required ack within 8 cycles", a);
    end
    @(posedge clk); #1;
  endtask

  // Drive new input values and let them settle; a differing value is a change.
  task automatic settle(input logic [31:0] n1, input logic [31:0] n2);
    gpi1_drv = n1; gpi2_drv = n2;
    repeat (6) @(posedge clk);
    #1;
    if (n1 !== m_gpi1) m_status[0] = 1'b1;
    if (n2 !== m_gpi2) m_status[1] = 1'b1;
    m_gpi1 = n1; m_gpi2 = n2;
  endtask

  task automatic test_reset;
    logic [31:0] r; int lat;
    rst = 1'b0; gpi1_drv = 32'd5; gpi2_drv = 32'd9;
    repeat (3) @(posedge clk);
    #1;
    checks++; if (ack !== 1'b0) begin failures++; $display("FAIL reset_ack got %b required 0", ack); end
    checks++; if (rd !== 32'h0) begin failures++; $display("FAIL reset_rd got %h required 0", rd); end
    checks++; if (gpO1 !== P_GPO1) begin failures++; $display("FAIL reset_gpo1 got %h required %h", gpO1, P_GPO1); end
    checks++; if (gpO2 !== P_GPO2) begin failures++; $display("FAIL reset_gpo2 got %h required %h", gpO2, P_GPO2); end
    checks++; if (irq !== 1'b0) begin failures++; $display("FAIL reset_irq got %b required 0", irq); end
    rst = 1'b1;
    m_gpo1 = P_GPO1; m_gpo2 = P_GPO2; m_gpi1 = 32'd5; m_gpi2 = 32'd9; m_status = 2'b00;
    repeat (5) @(posedge clk);
    #1;
    access(1'b0, 3'd0, 32'h0, r, lat);
    checks++; if (r !== 32'd5) begin failures++; $display("FAIL read_gpi1 got %h required 5", r); end
    checks++; if (lat != 2) begin failures++; $display("FAIL read_latency got %0d required 2", lat); end
    access(1'b0, 3'd4, 32'h0, r, lat);
    checks++; if (r !== 32'h0) begin failures++; $display("FAIL status_after_reset got %h required 0", r); end
  endtask

  task automatic test_write_gpo1;
    req = 1'b1; we = 1'b1; addr = 3'd2; wd = 32'hDEAD_BEEF;
    @(posedge clk); #1;
    checks++; if (ack !== 1'b0) begin failures++; $display("FAIL wr_ack_early got %b required 0", ack); end
    checks++; if (gpO1 !== m_gpo1) begin failures++; $display("FAIL wr_gpo1_early got %h required %h", gpO1, m_gpo1); end
    @(posedge clk); #1;
    checks++; if (ack !== 1'b1) begin failures++; $display("FAIL wr_ack got %b required 1", ack); end
    checks++; if (gpO1 !== 32'hDEAD_BEEF) begin failures++; $display("FAIL wr_gpo1 got %h required deadbeef", gpO1); end
    checks++; if (rd !== 32'hDEAD_BEEF) begin failures++; $display("FAIL wr_rd got %h required deadbeef", rd); end
    req = 1'b0; we = 1'b0;
    @(posedge clk); #1;
    checks++; if (ack !== 1'b0) begin failures++; $display("FAIL wr_ack_width got %b required 0", ack); end
    m_gpo1 = 32'hDEAD_BEEF;
  endtask

  task automatic test_irq_loopback;
    logic [31:0] r; int lat; int seen;
    loop_en = 1'b1;
    repeat (6) @(posedge clk);
    #1;
    access(1'b1, 3'd4, 32'd3, r, lat);
    m_status = 2'b00;
    access(1'b0, 3'd4, 32'h0, r, lat);
    checks++; if (r !== 32'h0) begin failures++; $display("FAIL loop_status_clear got %h required 0", r); end
    access(1'b1, 3'd2, 32'd7, r, lat);
    m_gpo1 = 32'd7;
    seen = 0;
    for (int i = 1; i <= 6; i++) begin
      @(posedge clk); #1;
      if (irq === 1'b1) begin seen = i; break; end
    end
    checks++; if (seen < 1 || seen > 3) begin failures++; $display("FAIL loop_irq_delay got %0d required 1..3", seen); end
    access(1'b0, 3'd4, 32'h0, r, lat);
    checks++; if (r !== 32'd2) begin failures++; $display("FAIL loop_status got %h required 2", r); end
    access(1'b1, 3'd4, 32'd2, r, lat);
    checks++; if (r !== 32'd0) begin failures++; $display("FAIL loop_w1c got %h required 0", r); end
    @(posedge clk); #1;
    checks++; if (irq !== 1'b0) begin failures++; $display("FAIL loop_irq_clear got %b required 0", irq); end
    m_status = 2'b00; m_gpi2 = 32'd7;
    loop_en = 1'b0;
    settle(m_gpi1, 32'd9);
  endtask

  task automatic test_w1c_race;
    logic [31:0] r; int lat; logic [31:0] n;
    access(1'b1, 3'd4, 32'd3, r, lat);
    m_status = 2'b00;
    settle(m_gpi1 ^ 32'h1, m_gpi2);
    access(1'b0, 3'd4, 32'h0, r, lat);
    checks++; if (r !== model_read(3'd4)) begin failures++; $display("FAIL race_pre got %h required %h", r, model_read(3'd4)); end
    n = m_gpi1 ^ 32'h10;
    gpi1_drv = n;
    @(posedge clk); #1;
    access(1'b1, 3'd4, 32'd1, r, lat);
    m_gpi1 = n; m_status[0] = 1'b1;
    checks++; if (r !== 32'd1) begin failures++; $display("FAIL race_rd got %h required 1", r); end
    repeat (4) @(posedge clk);
    #1;
    access(1'b0, 3'd4, 32'h0, r, lat);
    checks++; if (r !== 32'd1) begin failures++; $display("FAIL race_status got %h required 1", r); end
    access(1'b1, 3'd4, 32'd1, r, lat);
    m_status[0] = 1'b0;
    checks++; if (r !== model_read(3'd4)) begin failures++; $display("FAIL race_clear got %h required %h", r, model_read(3'd4)); end
  endtask

  task automatic test_back_to_back;
    logic [2:0] ops_a [5];
    logic       ops_w [5];
    logic [31:0] r; int lat; int k; int last; int gap;
    ops_a = '{3'd3, 3'd5, 3'd3, 3'd5, 3'd0};
    ops_w = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1};
    k = 0; last = 0;
    req = 1'b1; we = ops_w[0]; addr = ops_a[0]; wd = $urandom;
    for (int c = 1; c <= 30 && k < 5; c++) begin
      @(posedge clk); #1;
      if (ack === 1'b1) begin
        gap = c - last;
        checks++; if (gap != ((k == 0) ? 2 : 3)) begin failures++; $display("FAIL b2b_gap op=%0d got %0d required %0d", k, gap, (k == 0) ? 2 : 3); end
        checks++; if (rd !== model_read(ops_a[k])) begin failures++; $display("FAIL b2b_rd op=%0d got %h required %h", k, rd, model_read(ops_a[k])); end
        last = c; k++;
        if (k < 5) begin we = ops_w[k]; addr = ops_a[k]; end
        else begin req = 1'b0; we = 1'b0; end
      end
    end
    req = 1'b0; we = 1'b0;
    checks++; if (k != 5) begin failures++; $display("FAIL b2b_timeout got %0d acks required 5", k); end
    @(posedge clk); #1;
    access(1'b0, 3'd0, 32'h0, r, lat);
    checks++; if (r !== m_gpi1) begin failures++; $display("FAIL b2b_ro_write got %h required %h", r, m_gpi1); end
  endtask

  task automatic test_random;
    logic [31:0] r, d, exp; int lat; logic [2:0] a; logic w;
    access(1'b1, 3'd2, $urandom, r, lat); m_gpo1 = r;
    access(1'b1, 3'd3, $urandom, r, lat); m_gpo2 = r;
    for (int it = 0; it < 40; it++) begin
      if ($urandom_range(0, 7) == 0) begin
        settle(($urandom_range(0, 1) == 1) ? $urandom : m_gpi1,
               ($urandom_range(0, 1) == 1) ? $urandom : m_gpi2);
      end else begin
        a = 3'($urandom_range(0, 7));
        w = 1'($urandom_range(0, 1));
        d = $urandom;
        if (w) model_write(a, d);
        exp = model_read(a);
        access(w, a, d, r, lat);
        checks++; if (r !== exp) begin failures++; $display("FAIL rand_rd it=%0d a=%0d we=%b got %h required %h", it, a, w, r, exp); end
        checks++; if (gpO1 !== m_gpo1 || gpO2 !== m_gpo2) begin failures++; $display("FAIL rand_gpo it=%0d got %h/%h required %h/%h", it, gpO1, gpO2, m_gpo1, m_gpo2); end
        checks++; if (irq !== (|m_status)) begin failures++; $display("FAIL rand_irq it=%0d got %b required %b", it, irq, |m_status); end
      end
    end
  endtask

  task automatic test_reset_midwrite;
    logic [31:0] r; int lat; int acks;
    req = 1'b1; we = 1'b1; addr = 3'd3; wd = 32'hCAFE_F00D;
    @(posedge clk); #1;
    rst = 1'b0;
    #2;
    checks++; if (gpO2 !== P_GPO2) begin failures++; $display("FAIL midrst_gpo2 got %h required %h", gpO2, P_GPO2); end
    checks++; if (ack !== 1'b0 || rd !== 32'h0 || irq !== 1'b0) begin failures++; $display("FAIL midrst_outs got ack=%b rd=%h irq=%b required 0", ack, rd, irq); end
    req = 1'b0; we = 1'b0;
    @(posedge clk); #1;
    rst = 1'b1;
    m_gpo1 = P_GPO1; m_gpo2 = P_GPO2; m_status = 2'b00;
    acks = 0;
    repeat (5) begin @(posedge clk); #1; if (ack === 1'b1) acks++; end
    checks++; if (acks != 0) begin failures++; $display("FAIL midrst_ack got %0d pulses required 0", acks); end
    checks++; if (gpO2 !== P_GPO2) begin failures++; $display("FAIL midrst_nowrite got %h required %h", gpO2, P_GPO2); end
    access(1'b0, 3'd3, 32'h0, r, lat);
    checks++; if (r !== P_GPO2 || lat != 2) begin failures++; $display("FAIL midrst_idle got rd=%h lat=%0d required %h lat=2", r, lat, P_GPO2); end
    access(1'b0, 3'd4, 32'h0, r, lat);
    checks++; if (r !== 32'h0) begin failures++; $display("FAIL midrst_status got %h required 0", r); end
  endtask

  initial begin
    test_reset();
    test_write_gpo1();
    test_irq_loopback();
    test_w1c_race();
    test_back_to_back();
    test_random();
    test_reset_midwrite();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
